// File: rtl/line_wr_ctrl.sv
// Write-side controller for a ping-pong line buffer pair: fills one buffer per line, then releases it.
// Optional saturating stall counter is enabled by defining LINE_WR_STALL_CNT_EN.
module line_wr_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_LEN = 640,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [1:0]        buf_flag,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_rls
`ifdef LINE_WR_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    WRITE = 2'd1,
    REL   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              last_word;

  assign xfer      = in_valid && in_ready;
  assign last_word = (addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (!buf_flag[sel]) state_nxt = WRITE;
      WRITE:   if (xfer && last_word) state_nxt = REL;
      REL:     state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (state == WRITE) in_ready = 1'b1;
  end

  // Buffer select flips in REL so WAIT always checks the buffer about to be written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 1'b0;
      addr    <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_rls  <= '0;
    end else begin
      wr_en  <= xfer;
      wr_rls <= '0;
      if (xfer) begin
        wr_sel  <= sel;
        wr_addr <= addr;
        wr_data <= in_data;
        addr    <= last_word ? '0 : addr + 1'b1;
      end
      if (state == REL) begin
        wr_rls <= 2'b01 << sel;
        sel    <= ~sel;
      end
    end
  end

`ifdef LINE_WR_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == WAIT && buf_flag[sel] && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_wr_ctrl.sv
// Directed bench for line_wr_ctrl with LINE_LEN=4; checks stall_cnt when LINE_WR_STALL_CNT_EN is defined.
module tb_line_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [1:0] buf_flag;
  logic       wr_en;
  logic       wr_sel;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_rls;
`ifdef LINE_WR_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  line_wr_ctrl #(
    .DATA_W  (8),
    .LINE_LEN(4),
    .ADDR_W  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .buf_flag (buf_flag),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rls   (wr_rls)
`ifdef LINE_WR_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   32'(wr_en),    0);
    chk({tag, "_wr_sel"},  32'(wr_sel),   0);
    chk({tag, "_wr_addr"}, 32'(wr_addr),  0);
    chk({tag, "_wr_data"}, 32'(wr_data),  0);
    chk({tag, "_wr_rls"},  32'(wr_rls),   0);
    chk({tag, "_ready"},   32'(in_ready), 0);
`ifdef LINE_WR_STALL_CNT_EN
    chk({tag, "_stall"},   32'(stall_cnt), 0);
`endif
  endtask

  // Full line with in_valid held high; controller must already be in WRITE.
  task automatic feed_line(input string tag, input logic s, input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_ready_pre"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      tick();
      chk({tag, "_wr_en"},   32'(wr_en),   1);
      chk({tag, "_wr_sel"},  32'(wr_sel),  32'(s));
      chk({tag, "_wr_addr"}, 32'(wr_addr), i);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'(base + 8'(i)));
      chk({tag, "_rls_0"},   32'(wr_rls),  0);
    end
    chk({tag, "_ready_rel"}, 32'(in_ready), 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    buf_flag = 2'b00;
    #2;
    chk_reset_outputs("rst0");
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back lines with both buffers free
    chk("l1_wait_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    feed_line("l1", 1'b0, 8'hA0);
    tick();
    chk("l1_rls",       32'(wr_rls),   2'b01);
    chk("l1_en_off",    32'(wr_en),    0);
    chk("l1_ready_t2",  32'(in_ready), 0);
    tick();
    chk("l1_rls_clr",   32'(wr_rls),   0);
    chk("l1_ready_t3",  32'(in_ready), 1);
    feed_line("l2", 1'b1, 8'hB0);
    tick();
    chk("l2_rls",       32'(wr_rls),   2'b10);
    tick();
    chk("l2_rls_clr",   32'(wr_rls),   0);
    chk("l3_ready",     32'(in_ready), 1);
`ifdef LINE_WR_STALL_CNT_EN
    chk("l_stall_zero", 32'(stall_cnt), 0);
`endif
    in_valid = 1'b0;

    // Both buffers full after reset
    rst      = 1'b1;
    buf_flag = 2'b11;
    #1;
    chk_reset_outputs("rst1");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("full_ready", 32'(in_ready), 0);
    end
`ifdef LINE_WR_STALL_CNT_EN
    chk("full_stall10", 32'(stall_cnt), 10);
`endif
    buf_flag = 2'b10;
    tick();
    chk("free0_ready", 32'(in_ready), 1);
`ifdef LINE_WR_STALL_CNT_EN
    chk("free0_stall", 32'(stall_cnt), 10);
`endif

    // Gapped valid: accepts on alternate cycles, data from accepts only
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(i + 1);
      tick();
      chk("gap_en_on",   32'(wr_en),   1);
      chk("gap_addr_on", 32'(wr_addr), i);
      chk("gap_data_on", 32'(wr_data), 32'(8'h11 * 8'(i + 1)));
      chk("gap_sel",     32'(wr_sel),  0);
      in_valid = 1'b0;
      in_data  = 8'hEE;
      tick();
      if (i < 3) begin
        chk("gap_en_off",   32'(wr_en),   0);
        chk("gap_addr_hld", 32'(wr_addr), i);
        chk("gap_data_hld", 32'(wr_data), 32'(8'h11 * 8'(i + 1)));
      end else begin
        chk("gap_rls", 32'(wr_rls), 2'b01);
      end
    end
    tick();
    chk("gap_rls_clr",   32'(wr_rls),   0);
    chk("gap_blk_ready", 32'(in_ready), 0);

    // Reset mid-line
    rst      = 1'b1;
    buf_flag = 2'b00;
    #1;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_ready", 32'(in_ready), 1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      tick();
      chk("mid_addr", 32'(wr_addr), i);
    end
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    tick();
    rst = 1'b0;
    chk("mid_no_rls0", 32'(wr_rls), 0);
    tick();
    chk("mid_no_rls1", 32'(wr_rls), 0);
    chk("re_ready",    32'(in_ready), 1);
    feed_line("re", 1'b0, 8'hD0);
    tick();
    chk("re_rls", 32'(wr_rls), 2'b01);
    tick();
    chk("re_ready1", 32'(in_ready), 1);

    // Second line completes while buffer 0 is still full
    buf_flag = 2'b01;
    feed_line("hold", 1'b1, 8'hE0);
    tick();
    chk("hold_rls", 32'(wr_rls), 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_rls0",  32'(wr_rls),   0);
    end
    buf_flag = 2'b00;
    chk("hold_ready_same", 32'(in_ready), 0);
    tick();
    chk("hold_ready_go", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    chk("hold_sel0",  32'(wr_sel),  0);
    chk("hold_addr0", 32'(wr_addr), 0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
